stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a button level change (legal range 2..65535).
REQ-002 The block SHALL have parameter TICK_DIV, default 10, the number of run-state clock cycles per TICK pulse (legal range 2..65535).
REQ-003 The block SHALL have port CP, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port BTN_SS, input, 1 bit, the raw asynchronous start/stop button (high = pressed).
REQ-006 The block SHALL have port BTN_CLR, input, 1 bit, the raw asynchronous clear button.
REQ-007 The block SHALL have port BTN_LAP, input, 1 bit, the raw asynchronous lap button.
REQ-008 The block SHALL have port TICK, output, 1 bit, a one-cycle count-enable pulse to the downstream flip-flop counter chain.
REQ-009 The block SHALL have port CNT_CLR, output, 1 bit, a one-cycle clear pulse to the counter chain.
REQ-010 The block SHALL have port RUNNING, output, 1 bit, high in RUN or LAP.
REQ-011 The block SHALL have port LAP_HOLD, output, 1 bit, high in LAP (display freeze).
REQ-012 The block SHALL have port STATE, output, 2 bits, the FSM encoding: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer; the debounced level SHALL toggle at the edge where the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive edges, and the mismatch counter SHALL zero on any agreeing sample.
REQ-014 A press SHALL be a registered one-cycle pulse, high in the cycle after the debounced level rises; releases SHALL produce no pulse; a raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse.
REQ-015 The FSM SHALL change state at the edge sampling the press pulse, so that with the raw input stable before edge 1, STATE changes at edge DEBOUNCE_CYCLES+3.
REQ-016 IDLE transitions: SS -> RUN; CLR -> stay IDLE and pulse CNT_CLR; LAP ignored.
REQ-017 RUN transitions: SS -> PAUSE; LAP -> LAP; CLR ignored.
REQ-018 LAP transitions: LAP -> RUN; SS -> PAUSE (LAP_HOLD drops); CLR ignored; TICK continues throughout LAP.
REQ-019 PAUSE transitions: SS -> RUN; CLR -> IDLE and pulse CNT_CLR; LAP ignored.
REQ-020 Simultaneous presses SHALL resolve as follows: CLR beats SS in IDLE and PAUSE; SS beats LAP in RUN and LAP.
REQ-021 CNT_CLR SHALL be registered, high exactly one cycle, in the cycle after the clearing edge.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only while RUNNING, wrapping to 0, and SHALL hold its value in PAUSE (a fractional period is preserved across resume).
REQ-023 The prescaler SHALL zero on RST and on any clear.
REQ-024 TICK SHALL be high exactly in cycles where RUNNING=1 and prescaler=TICK_DIV-1, giving the first TICK in the TICK_DIV-th RUN cycle after IDLE->RUN.
REQ-025 TICK and CNT_CLR SHALL never be high in the same cycle.
REQ-026 RUNNING, LAP_HOLD and STATE SHALL be registered and consistent with each other every cycle.

Reset
REQ-027 At any edge with RST=1, the block SHALL reset STATE=IDLE, TICK=0, CNT_CLR=0, RUNNING=0, LAP_HOLD=0, the prescaler, synchronizers, debounced levels and mismatch counters to 0, and drop pending presses, overriding all other activity.
REQ-028 A button held across reset release SHALL be treated as a new press, accepted DEBOUNCE_CYCLES+3 edges after release.

Verification
REQ-029 Bench SHALL cover start: defaults, RST 2 cycles, BTN_SS high 12 cycles -> STATE=01 at edge 7 after assertion; TICK pulses every 10 cycles, first in the 10th RUN cycle.
REQ-030 Bench SHALL cover pause/resume: SS press after 15 RUN cycles (prescaler=5) -> PAUSE, no TICK; SS press again -> RUN, next TICK 5 cycles later.
REQ-031 Bench SHALL cover clear: in PAUSE assert BTN_SS and BTN_CLR together -> STATE=00, a single CNT_CLR pulse, prescaler 0; CLR in RUN -> ignored.
REQ-032 Bench SHALL cover lap: in RUN press LAP -> STATE=11, LAP_HOLD=1, TICK continues; LAP again -> STATE=01, LAP_HOLD=0.
REQ-033 Bench SHALL cover glitch rejection: BTN_SS high 3 cycles then low -> no state change, no pulse.
REQ-034 Bench SHALL cover reset mid-run: RST in RUN with BTN_SS held -> all outputs 0 at the next edge; after release, RUN entered at edge 7.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: three debounced buttons drive a four-state FSM that
// emits count-enable TICKs and counter-clear pulses for an external counter chain.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       BTN_SS,
    input  logic       BTN_CLR,
    input  logic       BTN_LAP,
    output logic       TICK,
    output logic       CNT_CLR,
    output logic       RUNNING,
    output logic       LAP_HOLD,
    output logic [1:0] STATE
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {BTN_LAP, BTN_CLR, BTN_SS};

    // Per-button synchronizer, mismatch-count debouncer and rising-edge press pulse.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic          sync1_reg;
        logic          sync2_reg;
        logic          level_reg;
        logic          press_reg;
        logic [DW-1:0] cnt_reg;

        always_ff @(posedge CP) begin
            if (RST) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                level_reg <= 1'b0;
                press_reg <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= btn_raw[gi];
                sync2_reg <= sync1_reg;
                press_reg <= 1'b0;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign press[gi] = press_reg;
    end

    state_t        state_reg, state_next;
    logic          clear_next;
    logic          running_reg, running_next;
    logic          lap_hold_reg;
    logic          cnt_clr_reg;
    logic          tick_reg, tick_next;
    logic [PW-1:0] presc_reg, presc_next;

    // press[0]=SS, press[1]=CLR, press[2]=LAP; branch order encodes priority.
    always_comb begin
        state_next = state_reg;
        clear_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (press[1])      clear_next = 1'b1;
                else if (press[0]) state_next = S_RUN;
            end
            S_RUN: begin
                if (press[0])      state_next = S_PAUSE;
                else if (press[2]) state_next = S_LAP;
            end
            S_LAP: begin
                if (press[0])      state_next = S_PAUSE;
                else if (press[2]) state_next = S_RUN;
            end
            S_PAUSE: begin
                if (press[1]) begin
                    clear_next = 1'b1;
                    state_next = S_IDLE;
                end else if (press[0]) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The prescaler advances only in cycles that are already running, so a
    // paused fraction of a period survives until the next resume.
    always_comb begin
        running_next = (state_next == S_RUN) || (state_next == S_LAP);
        presc_next   = presc_reg;
        if (clear_next) begin
            presc_next = '0;
        end else if (running_reg) begin
            presc_next = (presc_reg == DIV_LAST) ? '0 : presc_reg + 1'b1;
        end
        tick_next = running_next && (presc_next == DIV_LAST);
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            running_reg  <= 1'b0;
            lap_hold_reg <= 1'b0;
            cnt_clr_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            presc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            running_reg  <= running_next;
            lap_hold_reg <= (state_next == S_LAP);
            cnt_clr_reg  <= clear_next;
            tick_reg     <= tick_next;
            presc_reg    <= presc_next;
        end
    end

    assign STATE    = state_reg;
    assign RUNNING  = running_reg;
    assign LAP_HOLD = lap_hold_reg;
    assign CNT_CLR  = cnt_clr_reg;
    assign TICK     = tick_reg;

endmodule
